// File: rtl/sram_port_arbiter.sv
// Two-master arbiter and fixed-length access sequencer for the external 1Mx16 SRAM.
// All outputs are registered; strobes are active-low and only asserted in ACCESS.
//
// state  | meaning
// IDLE   | sample requests, grant one (round-robin on tie)
// ACCESS | strobes active for WAIT_CYCLES cycles, addr/data held
// DONE   | strobes released, one-cycle ack to the granted master
module sram_port_arbiter #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [19:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        cpu_ack,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [19:0] dma_addr,
  input  logic [15:0] dma_wdata,
  output logic [15:0] dma_rdata,
  output logic        dma_ack,
  output logic [19:0] ADDR,
  output logic [15:0] Data_to_SRAM,
  input  logic [15:0] Data_from_SRAM,
  output logic        Mem_CE,
  output logic        Mem_UB,
  output logic        Mem_LB,
  output logic        Mem_OE,
  output logic        Mem_WE,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        gnt_dma_q, gnt_dma_d;
  logic        we_q, we_d;
  logic        last_dma_q, last_dma_d;
  logic [19:0] addr_d;
  logic [15:0] wdata_d;
  logic [15:0] cpu_rdata_d, dma_rdata_d;
  logic        cpu_ack_d, dma_ack_d;
  logic        pick_dma;
  logic        strobe_d;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    gnt_dma_d   = gnt_dma_q;
    we_d        = we_q;
    last_dma_d  = last_dma_q;
    addr_d      = ADDR;
    wdata_d     = Data_to_SRAM;
    cpu_rdata_d = cpu_rdata;
    dma_rdata_d = dma_rdata;
    cpu_ack_d   = 1'b0;
    dma_ack_d   = 1'b0;
    // On a tie the master that did not win last time gets the port.
    pick_dma    = dma_req & (~cpu_req | ~last_dma_q);
    case (state_q)
      IDLE: begin
        if (cpu_req | dma_req) begin
          gnt_dma_d = pick_dma;
          we_d      = pick_dma ? dma_we    : cpu_we;
          addr_d    = pick_dma ? dma_addr  : cpu_addr;
          wdata_d   = pick_dma ? dma_wdata : cpu_wdata;
          cnt_d     = 4'd0;
          state_d   = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == LAST_CNT) begin
          if (!we_q) begin
            if (gnt_dma_q) dma_rdata_d = Data_from_SRAM;
            else           cpu_rdata_d = Data_from_SRAM;
          end
          last_dma_d = gnt_dma_q;
          cpu_ack_d  = ~gnt_dma_q;
          dma_ack_d  = gnt_dma_q;
          state_d    = DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    strobe_d = (state_d == ACCESS);
  end

  // Strobes and acks are registered from the next state so they line up with it.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt_q        <= 4'd0;
      gnt_dma_q    <= 1'b0;
      we_q         <= 1'b0;
      last_dma_q   <= 1'b1;
      ADDR         <= 20'd0;
      Data_to_SRAM <= 16'd0;
      cpu_rdata    <= 16'd0;
      dma_rdata    <= 16'd0;
      cpu_ack      <= 1'b0;
      dma_ack      <= 1'b0;
      Mem_CE       <= 1'b1;
      Mem_UB       <= 1'b1;
      Mem_LB       <= 1'b1;
      Mem_OE       <= 1'b1;
      Mem_WE       <= 1'b1;
      busy         <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      gnt_dma_q    <= gnt_dma_d;
      we_q         <= we_d;
      last_dma_q   <= last_dma_d;
      ADDR         <= addr_d;
      Data_to_SRAM <= wdata_d;
      cpu_rdata    <= cpu_rdata_d;
      dma_rdata    <= dma_rdata_d;
      cpu_ack      <= cpu_ack_d;
      dma_ack      <= dma_ack_d;
      Mem_CE       <= ~strobe_d;
      Mem_UB       <= ~strobe_d;
      Mem_LB       <= ~strobe_d;
      Mem_OE       <= ~(strobe_d & ~we_d);
      Mem_WE       <= ~(strobe_d & we_d);
      busy         <= (state_d != IDLE);
    end
  end

endmodule
